image_window_sender: RTL
========================

// Module: image_window_sender
// PURPOSE
// Next-generation grayscale image sender for the HDMI pixel pipeline. Holds two ping-pong image
// banks in inferred block RAM: the host fills the back bank and commits it, and the bank swap
// happens atomically at the frame boundary. The front bank replays every frame until a new commit.
// Image size, position and pixel depth are configurable. Sits between the AXI-fed host writer and
// the video timing generator, which supplies cx/cy.
// PARAMETERS
// FRAME_WIDTH     2200  total pixels per line (including blanking)
// FRAME_HEIGHT    1125  total lines per frame
// SCREEN_WIDTH    1920  active pixels per line
// SCREEN_HEIGHT   1080  active lines per frame
// BIT_WIDTH       12    width of cx and of the x-position/width ports
// BIT_HEIGHT      11    width of cy and of the y-position/height ports
// DATA_WIDTH      128   host write word width; must be a multiple of PIXEL_BITS
// PIXEL_BITS      8     grayscale bits per pixel (1..8); PPW = DATA_WIDTH/PIXEL_BITS pixels per word
// BANK_WORDS      2048  words per bank; AW = $clog2(BANK_WORDS)
// PORTS
// clk_pixel                in   1            pixel clock, the only clock in the block
// image_sender_reset       in   1            synchronous active-high reset
// image_sender_flush       in   1            discards back-bank contents and any pending commit
// image_sender_write       in   1            write strobe for one word into the back bank
// image_sender_fifo_din    in   DATA_WIDTH   image word; pixel k is at bits [k*PIXEL_BITS +: PIXEL_BITS]
// image_commit             in   1            marks the back bank complete; the swap happens at the next frame boundary
// cx / cy                  in   BIT_WIDTH / BIT_HEIGHT   current timing coordinates from the timing generator
// auto_start               in   1            display enable; sampled at the frame boundary
// img_x0 / img_y0          in   BIT_WIDTH / BIT_HEIGHT   window top-left corner; sampled at the frame boundary
// img_w / img_h            in   BIT_WIDTH / BIT_HEIGHT   window size in pixels; sampled at the frame boundary
// background               in   24           RGB shown in the active area outside the window
// rgb                      out  24           output pixel
// image_sender_full        out  1            back bank cannot accept writes
// image_sender_empty       out  1            back bank holds zero words
// require_new_image        out  1            1-cycle pulse when a bank swap occurs
// data_num                 out  AW+1         words held in the back bank
// frame_count              out  16           number of swaps since reset; wraps at 16 bits
// BEHAVIOUR
// - Frame boundary (FB) is the cycle in which cx==FRAME_WIDTH-1 and cy==FRAME_HEIGHT-1.
//   At FB the block latches auto_start, img_x0, img_y0, img_w and img_h. These ports are not re-read mid-frame.
// - Writes are accepted when image_sender_write && !image_sender_full. An accepted write stores the word at
//   back[data_num] and then increments data_num. Writes while full are dropped silently.
// - image_sender_full = commit_pending || (data_num==BANK_WORDS). image_sender_empty = (data_num==0).
// - image_commit sets commit_pending only when data_num!=0 and commit_pending==0; otherwise it is ignored.
//   A write and a commit in the same cycle: the write is accepted first, then pending is set.
// - Swap at FB when commit_pending: front and back banks exchange, front_valid is set, data_num is cleared
//   to 0, commit_pending is cleared, require_new_image pulses and frame_count increments.
//   If a commit arrives in the FB cycle itself, it waits for the next FB.
// - image_sender_flush clears data_num and commit_pending on the next edge; the front bank is untouched.
//   Flush wins over a same-cycle write or commit.
// - Window hit: x0<=cx<x0+w && y0<=cy<y0+h (all comparisons unsigned, at BIT_WIDTH+1 bits to avoid
//   overflow). w==0 or h==0 means no hit.
// - Pixel index = (cy-y0)*w + (cx-x0). Word address = index/PPW; lane = index%PPW.
//   The address is kept as a running counter with a line base, so no multiplier is used.
//   An address >= BANK_WORDS reads as pixel 0.
// - rgb for the (cx,cy) presented at cycle t appears at cycle t+2: one cycle for the RAM read, one for the output register.
// - rgb selection:
//     cx>=SCREEN_WIDTH or cy>=SCREEN_HEIGHT                  -> 24'h000000
//     no hit, or latched enable==0, or front_valid==0         -> background
//     otherwise, with pixel p                                 -> {g,g,g}, where g is p left-justified to 8 bits
//                                                                with its MSBs replicated into the low bits
// - Reset values: rgb=0, require_new_image=0, data_num=0, frame_count=0, commit_pending=0,
//   front_valid=0, latched enable=0. Reset mid-frame takes effect on the next edge; pipeline contents are discarded.
// CONFIGURATION
// - `IMAGE_SENDER_TEST_PATTERN_EN defined: adds input test_pattern (1 bit). When it is 1, a window hit shows
//   g=(cx-x0)[7:0], and this ignores front_valid. The bank logic is unaffected.
// - Macro undefined: no test_pattern port and no pattern logic.
// TESTING
// - Reset, enable=1, no commit, window 100x100 at (910,490), background=24'h112233
//   -> window and surround both show 112233; blanking shows 000000.
// - Write 625 words (PIXEL_BITS=8, 100x100 image) then commit -> full=1 until FB; at FB require_new_image
//   pulses once, data_num=0, frame_count=1. Pixel (910,490) shows byte0 of word0 on rgb two cycles later.
// - No further commit for 3 frames -> the same image replays identically; frame_count stays 1.
// - Write BANK_WORDS+5 words -> data_num saturates at BANK_WORDS and full=1; the extra 5 words are dropped.
// - Write 10 words, commit, then flush before FB -> no swap at FB; data_num=0; the old image remains displayed.
// - PIXEL_BITS=4, pixel value 4'hA -> rgb=24'hAAAAAA; commit with data_num=0 -> ignored, no pulse at FB.

Source files
------------

// File: rtl/image_window_sender.sv
// image_window_sender: ping-pong grayscale image banks replayed into a window of the HDMI raster.
// Optional `IMAGE_SENDER_TEST_PATTERN_EN adds a test_pattern input that shows a horizontal ramp in the window.
module image_window_sender #(
  parameter int FRAME_WIDTH   = 2200,
  parameter int FRAME_HEIGHT  = 1125,
  parameter int SCREEN_WIDTH  = 1920,
  parameter int SCREEN_HEIGHT = 1080,
  parameter int BIT_WIDTH     = 12,
  parameter int BIT_HEIGHT    = 11,
  parameter int DATA_WIDTH    = 128,
  parameter int PIXEL_BITS    = 8,
  parameter int BANK_WORDS    = 2048
) (
  input  logic                          clk_pixel,
  input  logic                          image_sender_reset,
  input  logic                          image_sender_flush,
  input  logic                          image_sender_write,
  input  logic [DATA_WIDTH-1:0]         image_sender_fifo_din,
  input  logic                          image_commit,
  input  logic [BIT_WIDTH-1:0]          cx,
  input  logic [BIT_HEIGHT-1:0]         cy,
  input  logic                          auto_start,
  input  logic [BIT_WIDTH-1:0]          img_x0,
  input  logic [BIT_HEIGHT-1:0]         img_y0,
  input  logic [BIT_WIDTH-1:0]          img_w,
  input  logic [BIT_HEIGHT-1:0]         img_h,
  input  logic [23:0]                   background,
`ifdef IMAGE_SENDER_TEST_PATTERN_EN
  input  logic                          test_pattern,
`endif
  output logic [23:0]                   rgb,
  output logic                          image_sender_full,
  output logic                          image_sender_empty,
  output logic                          require_new_image,
  output logic [$clog2(BANK_WORDS):0]   data_num,
  output logic [15:0]                   frame_count
);
  localparam int PPW = DATA_WIDTH / PIXEL_BITS;
  localparam int AW  = $clog2(BANK_WORDS);
  localparam int LW  = PPW > 1 ? $clog2(PPW) : 1;
  localparam int IW  = BIT_WIDTH + BIT_HEIGHT + 1;

  logic [DATA_WIDTH-1:0] mem [2*BANK_WORDS];
  logic [DATA_WIDTH-1:0] rd_word, rd_shift;
  logic front_sel, front_valid, pending, en_q;
  logic [BIT_WIDTH-1:0] x0_q, w_q, dx;
  logic [BIT_HEIGHT-1:0] y0_q, h_q;
  logic [IW-1:0] line_base, pix_idx, word_idx;
  logic [LW-1:0] lane, s_lane;
  logic fb, line_end, x_hit, y_hit, hit, show, wr_acc, commit_ok, swap;
  logic s_blank, s_show, s_oob;
  logic [PIXEL_BITS-1:0] pix;
  logic [7:0] g, g_sel;

  assign line_end = cx == BIT_WIDTH'(FRAME_WIDTH - 1);
  assign fb       = line_end && cy == BIT_HEIGHT'(FRAME_HEIGHT - 1);
  assign x_hit    = {1'b0, cx} >= {1'b0, x0_q} && {1'b0, cx} < {1'b0, x0_q} + {1'b0, w_q};
  assign y_hit    = {1'b0, cy} >= {1'b0, y0_q} && {1'b0, cy} < {1'b0, y0_q} + {1'b0, h_q};
  assign hit      = x_hit && y_hit;
  // line_base holds (cy-y0)*w for the current window row, so the index needs only an adder
  assign dx       = cx - x0_q;
  assign pix_idx  = line_base + IW'(dx);
  assign word_idx = pix_idx / IW'(PPW);
  assign lane     = LW'(pix_idx % IW'(PPW));

  assign image_sender_full  = pending || data_num == (AW+1)'(BANK_WORDS);
  assign image_sender_empty = data_num == '0;
  assign wr_acc    = image_sender_write && !image_sender_full && !image_sender_flush;
  assign commit_ok = image_commit && !image_sender_flush && !pending && (!image_sender_empty || wr_acc);
  assign swap      = fb && pending && !image_sender_flush;
`ifdef IMAGE_SENDER_TEST_PATTERN_EN
  assign show = hit && en_q && (front_valid || test_pattern);
`else
  assign show = hit && en_q && front_valid;
`endif

  always_ff @(posedge clk_pixel) begin
    if (image_sender_reset) begin
      data_num          <= '0;
      pending           <= 1'b0;
      front_sel         <= 1'b0;
      front_valid       <= 1'b0;
      require_new_image <= 1'b0;
      frame_count       <= '0;
      en_q              <= 1'b0;
      x0_q              <= '0;
      y0_q              <= '0;
      w_q               <= '0;
      h_q               <= '0;
      line_base         <= '0;
    end else begin
      require_new_image <= swap;
      if (fb) begin
        en_q <= auto_start;
        x0_q <= img_x0;
        y0_q <= img_y0;
        w_q  <= img_w;
        h_q  <= img_h;
      end
      line_base <= fb ? '0 : (line_end && y_hit) ? line_base + IW'(w_q) : line_base;
      if (image_sender_flush) begin
        data_num <= '0;
        pending  <= 1'b0;
      end else if (swap) begin
        data_num    <= '0;
        pending     <= 1'b0;
        front_sel   <= ~front_sel;
        front_valid <= 1'b1;
        frame_count <= frame_count + 1'b1;
      end else begin
        if (wr_acc) data_num <= data_num + 1'b1;
        if (commit_ok) pending <= 1'b1;
      end
    end
  end

  // both banks share one RAM; front_sel is the bank-select address bit
  always_ff @(posedge clk_pixel) begin
    if (wr_acc) mem[{~front_sel, data_num[AW-1:0]}] <= image_sender_fifo_din;
    rd_word <= mem[{front_sel, word_idx[AW-1:0]}];
  end

`ifdef IMAGE_SENDER_TEST_PATTERN_EN
  logic s_tp;
  logic [7:0] s_tpg;
  always_ff @(posedge clk_pixel) begin
    if (image_sender_reset) begin
      s_tp  <= 1'b0;
      s_tpg <= '0;
    end else begin
      s_tp  <= test_pattern;
      s_tpg <= dx[7:0];
    end
  end
  assign g_sel = s_tp ? s_tpg : g;
`else
  assign g_sel = g;
`endif

  always_ff @(posedge clk_pixel) begin
    if (image_sender_reset) begin
      s_blank <= 1'b1;
      s_show  <= 1'b0;
      s_oob   <= 1'b0;
      s_lane  <= '0;
      rgb     <= '0;
    end else begin
      s_blank <= cx >= BIT_WIDTH'(SCREEN_WIDTH) || cy >= BIT_HEIGHT'(SCREEN_HEIGHT);
      s_show  <= show;
      s_oob   <= word_idx >= IW'(BANK_WORDS);
      s_lane  <= lane;
      rgb     <= s_blank ? '0 : s_show ? {g_sel, g_sel, g_sel} : background;
    end
  end

  assign rd_shift = rd_word >> (s_lane * PIXEL_BITS);
  assign pix      = s_oob ? '0 : rd_shift[PIXEL_BITS-1:0];

  // left-justify the pixel and refill the low bits with repeated MSBs
  always_comb begin
    g = '0;
    for (int i = 0; i < 8; i++) g[7-i] = pix[PIXEL_BITS-1-(i%PIXEL_BITS)];
  end
endmodule
